// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe
//   Signed multiply-accumulate stage with a configurable product pipeline.
//   Each accepted beat forms i*c. The product travels through PIPE_DEPTH
//   registers and is then summed into the running frame accumulator. The
//   frame total is emitted on `o` when the beat flagged in_last is summed.
//   The code is behavioural so that the multiplier, the pipeline registers
//   and the accumulator can all map into a single DSP slice.
//
// Parameters
//   DATA_W      width of i and c (signed)
//   ACC_W       accumulator / result width, >= 2*DATA_W
//   PIPE_DEPTH  product registers between input and accumulator (0..4)
//
// Optional build macro
//   DSP_MAC_SAT_EN  defined   : accumulation saturates, ovf is a sticky flag
//                   undefined : accumulation wraps mod 2^ACC_W, ovf = 0
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake
//   i, c, in_last        sample, coefficient, end-of-frame marker
//   out_valid/out_ready  output handshake
//   o                    completed frame sum
//   busy                 frame open, beat in flight or result pending
//   ovf                  sticky saturation flag
module dsp_mac_pipe #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ACC_W      = 48,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] i,
  input  logic signed [DATA_W-1:0] c,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  o,
  output logic                     busy,
  output logic                     ovf
);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                    w_advance;
  logic                    w_accept;
  logic signed [2*DATA_W-1:0] w_i_ext;
  logic signed [2*DATA_W-1:0] w_c_ext;
  logic signed [2*DATA_W-1:0] w_mul;
  logic signed [ACC_W-1:0] w_prod;

  // Product as seen by the accumulator stage
  logic                    w_av;
  logic signed [ACC_W-1:0] w_ad;
  logic                    w_al;
  logic                    w_pipe_busy;

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_o;
  logic                    r_out_valid;

  logic                    w_load;
  logic                    w_emit;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_add_res;

  // The whole stage stalls only while a finished result waits downstream
  assign w_advance = !(r_out_valid && !out_ready);
  assign in_ready  = w_advance;
  assign w_accept  = in_valid && w_advance;

  assign w_i_ext = {{DATA_W{i[DATA_W-1]}}, i};
  assign w_c_ext = {{DATA_W{c[DATA_W-1]}}, c};
  assign w_mul   = w_i_ext * w_c_ext;
  assign w_prod  = ACC_W'(w_mul);

  generate
    if (PIPE_DEPTH == 0) begin : g_comb
      assign w_av        = w_accept;
      assign w_ad        = w_prod;
      assign w_al        = in_last;
      assign w_pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [PIPE_DEPTH-1:0]   r_pv;
      logic [PIPE_DEPTH-1:0]   r_pl;
      logic signed [ACC_W-1:0] r_pd [PIPE_DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pv <= '0;
          r_pl <= '0;
          for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
            r_pd[k] <= '0;
          end
        end else if (w_advance) begin
          r_pv[0] <= w_accept;
          r_pl[0] <= in_last;
          r_pd[0] <= w_prod;
          for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
            r_pv[k] <= r_pv[k-1];
            r_pl[k] <= r_pl[k-1];
            r_pd[k] <= r_pd[k-1];
          end
        end
      end

      assign w_av        = r_pv[PIPE_DEPTH-1];
      assign w_ad        = r_pd[PIPE_DEPTH-1];
      assign w_al        = r_pl[PIPE_DEPTH-1];
      assign w_pipe_busy = |r_pv;
    end
  endgenerate

`ifdef DSP_MAC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] w_raw;
  logic                    w_add_ovf;
  logic                    r_ovf;

  // Signed overflow: both operands share a sign the raw sum does not have
  always_comb begin
    w_raw     = r_acc + w_ad;
    w_add_ovf = (r_acc[ACC_W-1] == w_ad[ACC_W-1]) &&
                (w_raw[ACC_W-1] != r_acc[ACC_W-1]);
    w_add_res = w_raw;
    if (w_add_ovf) begin
      w_add_res = r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_load && (r_state == S_ACCUM) && w_add_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_add_res = r_acc + w_ad;
  assign ovf       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_emit      = 1'b0;
    w_sum       = w_ad;
    if (w_advance && w_av) begin
      w_load = 1'b1;
      if (r_state == S_ACCUM) begin
        w_sum = w_add_res;
      end
      if (w_al) begin
        w_emit      = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_ACCUM;
      end
    end
  end

  // A new emit takes priority over the downstream consume on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_o         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_acc <= w_sum;
      end
      if (w_emit) begin
        r_o         <= w_sum;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o         = r_o;
  assign out_valid = r_out_valid;
  assign busy      = (r_state == S_ACCUM) || w_pipe_busy || r_out_valid;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
module tb_dsp_mac_pipe;

  localparam int DEP  [3] = '{2, 0, 1};
  localparam int ACCW [3] = '{48, 48, 32};
`ifdef DSP_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic signed [15:0] si = '0;
  logic signed [15:0] sc = '0;

  logic [2:0] ir, ov, bz, of;
  logic signed [47:0] o0, o1;
  logic signed [31:0] o2;
  longint obs [3];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // stimulus list shared by the directed scenarios
  bit                 bv [$];
  bit                 bl [$];
  logic signed [15:0] bi [$];
  logic signed [15:0] bc [$];

  longint q0 [$];
  longint q1 [$];
  longint q2 [$];
  longint eq [$];
  bit     eovf;
  int first_ov [3];
  int last_ov  [3];
  int bfall    [3];
  bit rdy_low  [3];
  int tfirst, tlast;

  dsp_mac_pipe #(.DATA_W(16), .ACC_W(48), .PIPE_DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .i(si), .c(sc),
    .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .o(o0),
    .busy(bz[0]), .ovf(of[0]));

  dsp_mac_pipe #(.DATA_W(16), .ACC_W(48), .PIPE_DEPTH(0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .i(si), .c(sc),
    .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .o(o1),
    .busy(bz[1]), .ovf(of[1]));

  dsp_mac_pipe #(.DATA_W(16), .ACC_W(32), .PIPE_DEPTH(1)) u_a32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .i(si), .c(sc),
    .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .o(o2),
    .busy(bz[2]), .ovf(of[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    obs[0] = longint'(o0);
    obs[1] = longint'(o1);
    obs[2] = longint'(o2);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic longint wrapv(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) <<< w;
    r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  function automatic longint model_frame(input longint p [$], input int w, inout bit fl);
    longint acc, s, mx, mn;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -(longint'(1) <<< (w - 1));
    acc = 0;
    foreach (p[k]) begin
      if (k == 0) begin
        acc = p[k];
      end else begin
        s = acc + p[k];
        if (SAT && s > mx) begin acc = mx; fl = 1'b1; end
        else if (SAT && s < mn) begin acc = mn; fl = 1'b1; end
        else acc = wrapv(s, w);
      end
    end
    return acc;
  endfunction

  task automatic model_run(input int w);
    longint p [$];
    eq.delete();
    eovf = 1'b0;
    foreach (bv[k]) begin
      if (bv[k]) begin
        p.push_back(longint'(bi[k]) * longint'(bc[k]));
        if (bl[k]) begin
          eq.push_back(model_frame(p, w, eovf));
          p.delete();
        end
      end
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic clear_beats();
    bv.delete(); bl.delete(); bi.delete(); bc.delete();
  endtask

  task automatic add(input bit v, input int a, input int b, input bit l);
    bv.push_back(v);
    bi.push_back(16'(a));
    bc.push_back(16'(b));
    bl.push_back(l);
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic longint qat(input int k, input int idx);
    longint sentinel;
    sentinel = 64'sh8000_0000_0000_0000;
    if (idx >= qsize(k)) return sentinel;
    case (k)
      0: return q0[idx];
      1: return q1[idx];
      default: return q2[idx];
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic sample();
    for (int k = 0; k < 3; k++) begin
      if (ov[k]) begin
        if (first_ov[k] < 0) first_ov[k] = cyc;
        last_ov[k] = cyc;
      end
      if (first_ov[k] >= 0 && !bz[k] && bfall[k] < 0) bfall[k] = cyc;
      if (!ir[k]) rdy_low[k] = 1'b1;
      if (ov[k] && out_ready) begin
        case (k)
          0: q0.push_back(obs[0]);
          1: q1.push_back(obs[1]);
          default: q2.push_back(obs[2]);
        endcase
      end
    end
  endtask

  task automatic run_beats(input int tail);
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) begin
      first_ov[k] = -1; last_ov[k] = -1; bfall[k] = -1; rdy_low[k] = 1'b0;
    end
    tfirst = -1;
    tlast = -1;
    out_ready = 1'b1;
    foreach (bv[k]) begin
      in_valid = bv[k];
      si = bi[k];
      sc = bc[k];
      in_last = bl[k];
      @(negedge clk);
      if (bv[k]) begin
        if (tfirst < 0) tfirst = cyc;
        if (bl[k]) tlast = cyc;
      end
      sample();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    si = '0;
    sc = '0;
    repeat (tail) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({ov[k], bz[k], of[k], ir[k]} !== 4'b0001 || obs[k] !== 64'sd0) begin
        n_err++;
        $display("FAIL reset[%0d]: got ov=%b busy=%b ovf=%b rdy=%b o=%0d, expected 0 0 0 1 0",
                 k, ov[k], bz[k], of[k], ir[k], obs[k]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    clear_beats();
    add(1, 3, 4, 0);
    add(1, -5, 2, 0);
    add(1, 7, 7, 1);
    run_beats(8);
    for (int k = 0; k < 3; k++) begin
      model_run(ACCW[k]);
      n_vec++;
      if (qsize(k) != 1 || qat(k, 0) !== eq[0]) begin
        n_err++;
        $display("FAIL basic_sum[%0d]: got %0d results, first %0d; expected 1 result %0d",
                 k, qsize(k), qat(k, 0), eq[0]);
      end
      n_vec++;
      if (first_ov[k] - tlast !== DEP[k] + 1) begin
        n_err++;
        $display("FAIL basic_latency[%0d]: got %0d cycles, expected %0d",
                 k, first_ov[k] - tlast, DEP[k] + 1);
      end
      n_vec++;
      if (last_ov[k] !== first_ov[k] || bfall[k] !== last_ov[k] + 1) begin
        n_err++;
        $display("FAIL basic_busy[%0d]: out_valid %0d..%0d busy low at %0d, expected one cycle then busy low next",
                 k, first_ov[k], last_ov[k], bfall[k]);
      end
    end
    n_vec++;
    if (q0.size() != 1 || q0[0] !== 64'sd51) begin
      n_err++;
      $display("FAIL basic_51: got %0d, expected 51", qat(0, 0));
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_beats();
    add(1, 2, 3, 1);
    add(1, -1, -1, 1);
    add(1, 100, -2, 1);
    run_beats(6);
    for (int k = 0; k < 3; k++) begin
      model_run(ACCW[k]);
      n_vec++;
      if (qsize(k) != 3) begin
        n_err++;
        $display("FAIL b2b_count[%0d]: got %0d, expected 3", k, qsize(k));
      end
      for (int n = 0; n < 3; n++) begin
        n_vec++;
        if (qat(k, n) !== eq[n]) begin
          n_err++;
          $display("FAIL b2b_value[%0d][%0d]: got %0d, expected %0d", k, n, qat(k, n), eq[n]);
        end
      end
      n_vec++;
      if (first_ov[k] !== tfirst + DEP[k] + 1 || last_ov[k] !== first_ov[k] + 2 || rdy_low[k]) begin
        n_err++;
        $display("FAIL b2b_rate[%0d]: out_valid %0d..%0d rdy_low=%b, expected %0d..%0d rdy_low=0",
                 k, first_ov[k], last_ov[k], rdy_low[k], tfirst + DEP[k] + 1, tfirst + DEP[k] + 3);
      end
    end
  endtask

  task automatic test_bubbles();
    do_reset();
    clear_beats();
    add(1, 1, 1, 0);
    add(0, 0, 0, 0);
    add(0, 9, 9, 1);
    add(1, 2, 2, 0);
    add(1, 3, 3, 1);
    run_beats(8);
    for (int k = 0; k < 3; k++) begin
      model_run(ACCW[k]);
      n_vec++;
      if (qsize(k) != 1 || qat(k, 0) !== eq[0] || qat(k, 0) !== 64'sd14) begin
        n_err++;
        $display("FAIL bubbles[%0d]: got %0d results, first %0d; expected 1 result %0d",
                 k, qsize(k), qat(k, 0), eq[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] ti [4] = '{16'sd5, 16'sd1, 16'sd3, 16'sd2};
    logic signed [15:0] tc [4] = '{16'sd6, 16'sd2, 16'sd4, 16'sd2};
    bit tl [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    longint p [$];
    longint exp_v [2];
    bit fl;
    bit exp_rdy, acc;
    int idx, stall, got;
    fl = 1'b0;
    p.push_back(30);
    exp_v[0] = model_frame(p, 48, fl);
    p.delete();
    p.push_back(2); p.push_back(12); p.push_back(4);
    exp_v[1] = model_frame(p, 48, fl);
    idx = 0; stall = 0; got = 0;
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 60 && got < 2; n++) begin
      if (idx < 4) begin
        in_valid = 1'b1; si = ti[idx]; sc = tc[idx]; in_last = tl[idx];
      end else begin
        in_valid = 1'b0; si = '0; sc = '0; in_last = 1'b0;
      end
      @(negedge clk);
      exp_rdy = !(ov[0] && !out_ready);
      n_vec++;
      if (ir[0] !== exp_rdy) begin
        n_err++;
        $display("FAIL bp_ready: got %b, expected %b (cycle %0d)", ir[0], exp_rdy, cyc);
      end
      acc = in_valid && exp_rdy;
      if (ov[0] && !out_ready) begin
        stall++;
        n_vec++;
        if (obs[0] !== exp_v[0] || bz[0] !== 1'b1) begin
          n_err++;
          $display("FAIL bp_hold: got o=%0d busy=%b, expected o=%0d busy=1", obs[0], bz[0], exp_v[0]);
        end
      end
      if (ov[0] && out_ready) begin
        n_vec++;
        if (obs[0] !== exp_v[got]) begin
          n_err++;
          $display("FAIL bp_value[%0d]: got %0d, expected %0d", got, obs[0], exp_v[got]);
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) idx++;
      if (stall >= 4) out_ready = 1'b1;
    end
    n_vec++;
    if (got != 2 || idx != 4) begin
      n_err++;
      $display("FAIL bp_complete: got %0d results %0d beats, expected 2 results 4 beats", got, idx);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset_midframe();
    do_reset();
    clear_beats();
    add(1, 10, 10, 0);
    add(1, 10, 10, 0);
    run_beats(0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (bz[k] !== 1'b1) begin
        n_err++;
        $display("FAIL mid_busy[%0d]: got %b, expected 1", k, bz[k]);
      end
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({ov[k], bz[k], of[k]} !== 3'b000 || obs[k] !== 64'sd0) begin
        n_err++;
        $display("FAIL mid_rst_out[%0d]: got ov=%b busy=%b ovf=%b o=%0d, expected all 0",
                 k, ov[k], bz[k], of[k], obs[k]);
      end
    end
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_beats();
    add(1, 1, 1, 1);
    run_beats(6);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (qsize(k) != 1 || qat(k, 0) !== 64'sd1 || of[k] !== 1'b0) begin
        n_err++;
        $display("FAIL mid_after[%0d]: got %0d results first %0d ovf=%b, expected 1 result 1 ovf=0",
                 k, qsize(k), qat(k, 0), of[k]);
      end
    end
  endtask

  task automatic test_overflow();
    longint exp_c;
    do_reset();
    clear_beats();
    add(1, -32768, -32768, 0);
    add(1, -32768, -32768, 0);
    add(1, -32768, -32768, 1);
    run_beats(7);
    for (int k = 0; k < 3; k++) begin
      model_run(ACCW[k]);
      n_vec++;
      if (qsize(k) != 1 || qat(k, 0) !== eq[0] || of[k] !== eovf) begin
        n_err++;
        $display("FAIL ovf_model[%0d]: got %0d ovf=%b, expected %0d ovf=%b",
                 k, qat(k, 0), of[k], eq[0], eovf);
      end
    end
    exp_c = SAT ? 64'sd2147483647 : -64'sd1073741824;
    n_vec++;
    if (qat(2, 0) !== exp_c || of[2] !== SAT) begin
      n_err++;
      $display("FAIL ovf_acc32: got %0d ovf=%b, expected %0d ovf=%b", qat(2, 0), of[2], exp_c, SAT);
    end
    n_vec++;
    if (qat(0, 0) !== 64'sd3221225472) begin
      n_err++;
      $display("FAIL ovf_acc48: got %0d, expected 3221225472", qat(0, 0));
    end
    clear_beats();
    add(1, 1, 1, 1);
    run_beats(5);
    n_vec++;
    if (of[2] !== SAT || qat(2, 0) !== 64'sd1) begin
      n_err++;
      $display("FAIL ovf_sticky: got ovf=%b o=%0d, expected ovf=%b o=1", of[2], qat(2, 0), SAT);
    end
  endtask

  task automatic test_random();
    longint cur [$];
    longint expq [$];
    longint e;
    bit movf, exp_rdy;
    movf = 1'b0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      out_ready = ($urandom_range(99) < 70);
      in_valid  = ($urandom_range(99) < 75);
      in_last   = ($urandom_range(99) < 30);
      si = 16'($urandom);
      sc = 16'($urandom);
      @(negedge clk);
      exp_rdy = !(ov[0] && !out_ready);
      n_vec++;
      if (ir[0] !== exp_rdy) begin
        n_err++;
        $display("FAIL rnd_ready: got %b, expected %b (cycle %0d)", ir[0], exp_rdy, cyc);
      end
      if (ov[0] && out_ready) begin
        e = (expq.size() > 0) ? expq.pop_front() : 64'sh8000_0000_0000_0000;
        n_vec++;
        if (obs[0] !== e) begin
          n_err++;
          $display("FAIL rnd_value: got %0d, expected %0d (cycle %0d)", obs[0], e, cyc);
        end
      end
      if (in_valid && exp_rdy) begin
        cur.push_back(longint'(si) * longint'(sc));
        if (in_last) begin
          expq.push_back(model_frame(cur, 48, movf));
          cur.delete();
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ov[0]) begin
        e = (expq.size() > 0) ? expq.pop_front() : 64'sh8000_0000_0000_0000;
        n_vec++;
        if (obs[0] !== e) begin
          n_err++;
          $display("FAIL rnd_drain: got %0d, expected %0d", obs[0], e);
        end
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (expq.size() != 0 || of[0] !== movf) begin
      n_err++;
      $display("FAIL rnd_final: got %0d results missing ovf=%b, expected 0 missing ovf=%b",
               expq.size(), of[0], movf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_bubbles();
    test_backpressure();
    test_reset_midframe();
    test_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
